// File: rtl/mem_store_unit.sv
// mem_store_unit: in-order store buffer between the MEM stage and the data cache.
// Word and byte stores are mapped onto byte lanes in the same order that the
// load path reads them back. They are queued, then drained one per cache_ack.
// The processor `halted` output is held low until every queued store has drained.
//
// Optional feature: define STORE_MISALIGN_TRAP_EN to reject word stores whose
// address bits [1:0] are non-zero. Such a store raises a one-cycle `misaligned`
// pulse. Without the macro, a word store is aligned down and `misaligned` is tied to 0.

module mem_store_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic              st_is_word,
    output logic              cache_req,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [7:0]        cache_data_in [0:3],
    output logic [3:0]        cache_byte_en,
    input  logic              cache_ack,
    input  logic              halted_controller,
    output logic              halted,
    output logic              buf_empty,
    output logic              misaligned
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    // One buffered write: the aligned address, four lanes packed with lane i at
    // bits [8i+7:8i], and the per-lane enables.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    state_e             state_q, state_d;
    entry_t             head_q, head_d;
    logic               halted_q, halted_d;

    entry_t             in_entry;
    logic               handshake;
    logic               push;
    logic               pop;

    // These three outputs are decoded from registered state only.
    assign buf_empty = (count_q == '0);
    assign cache_req = !buf_empty;
    assign st_ready  = (count_q < CNT_W'(DEPTH)) && (state_q == RUN);

    assign handshake = st_valid && st_ready;
    assign pop       = cache_req && cache_ack;

    // Map an incoming store onto the cache lanes the load path reads back.
    // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        in_entry      = '0;
        in_entry.addr = {st_addr[ADDR_W-1:2], 2'b00};
        if (st_is_word) begin
            in_entry.data = st_data;
            in_entry.be   = 4'b1111;
        end else begin
            case (st_addr[1:0])
                2'd0: begin in_entry.data = {st_data[7:0], 24'h0};        in_entry.be = 4'b1000; end
                2'd1: begin in_entry.data = {8'h0, st_data[7:0], 16'h0};  in_entry.be = 4'b0100; end
                2'd2: begin in_entry.data = {16'h0, st_data[7:0], 8'h0};  in_entry.be = 4'b0010; end
                default: begin in_entry.data = {24'h0, st_data[7:0]};     in_entry.be = 4'b0001; end
            endcase
        end
    end

`ifdef STORE_MISALIGN_TRAP_EN
    logic word_misaligned;
    logic misaligned_q;

    assign word_misaligned = st_is_word && (st_addr[1:0] != 2'b00);
    assign push            = handshake && !word_misaligned;
    assign misaligned      = misaligned_q;

    // One-cycle trap pulse, raised on the cycle after a rejected word store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= handshake && word_misaligned;
        end
    end
`else
    assign push       = handshake;
    assign misaligned = 1'b0;
`endif

    // Next state for the pointers, the occupancy count, the registered head copy and the halt FSM.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The head register always shows the entry at rd_ptr_d. That slot is being
        // written this cycle only when the buffer drains to the incoming store, so
        // in that case the head is taken from the bypass path.
        head_d = head_q;
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = in_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        state_d = state_q;
        case (state_q)
            RUN: begin
                if (halted_controller) begin
                    state_d = ((count_q == '0) && !push) ? HALTED : DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase

        halted_d = (state_d == HALTED);
    end

    // Control state: the pointers, count, head copy, FSM and halted flag.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Buffer storage, written at the tail on each accepted store.
    // NOTE: the storage array has no reset, because the count and pointers already mark every slot invalid after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    // Registered cache-side view of the head entry.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cache_data_in[i] = head_q.data[8*i +: 8];
        end
    end

    assign cache_addr    = head_q.addr;
    assign cache_byte_en = head_q.be;
    assign halted        = halted_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: directed test of mem_store_unit. Inputs change 1 ns after
// each rising edge, and outputs are checked at that same point.

module tb_mem_store_unit;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_is_word;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic [7:0]  cache_data_in [0:3];
    logic [3:0]  cache_byte_en;
    logic        cache_ack;
    logic        halted_controller;
    logic        halted;
    logic        buf_empty;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    mem_store_unit #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .st_addr           (st_addr),
        .st_data           (st_data),
        .st_is_word        (st_is_word),
        .cache_req         (cache_req),
        .cache_addr        (cache_addr),
        .cache_data_in     (cache_data_in),
        .cache_byte_en     (cache_byte_en),
        .cache_ack         (cache_ack),
        .halted_controller (halted_controller),
        .halted            (halted),
        .buf_empty         (buf_empty),
        .misaligned        (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed lanes, packed as {lane3, lane2, lane1, lane0}.
    function automatic logic [31:0] lanes();
        return {cache_data_in[3], cache_data_in[2], cache_data_in[1], cache_data_in[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        st_valid          = 1'b0;
        st_addr           = '0;
        st_data           = '0;
        st_is_word        = 1'b0;
        cache_ack         = 1'b0;
        halted_controller = 1'b0;
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++; if (st_ready !== 1'b1)       begin n_fail++; $display("FAIL reset_st_ready: got %0b want 1", st_ready); end
        n_checks++; if (cache_req !== 1'b0)      begin n_fail++; $display("FAIL reset_cache_req: got %0b want 0", cache_req); end
        n_checks++; if (cache_addr !== 32'h0)    begin n_fail++; $display("FAIL reset_cache_addr: got %h want 0", cache_addr); end
        n_checks++; if (lanes() !== 32'h0)       begin n_fail++; $display("FAIL reset_lanes: got %h want 0", lanes()); end
        n_checks++; if (cache_byte_en !== 4'h0)  begin n_fail++; $display("FAIL reset_byte_en: got %b want 0000", cache_byte_en); end
        n_checks++; if (halted !== 1'b0)         begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
        n_checks++; if (buf_empty !== 1'b1)      begin n_fail++; $display("FAIL reset_buf_empty: got %0b want 1", buf_empty); end
        n_checks++; if (misaligned !== 1'b0)     begin n_fail++; $display("FAIL reset_misaligned: got %0b want 0", misaligned); end
        do_reset();
    endtask

    task automatic test_word_store();
        cache_ack  = 1'b1;
        st_valid   = 1'b1;
        st_is_word = 1'b1;
        st_addr    = 32'h100;
        st_data    = 32'hDEADBEEF;
        tick();
        st_valid = 1'b0;
        n_checks++; if (cache_req !== 1'b1)          begin n_fail++; $display("FAIL word_req: got %0b want 1", cache_req); end
        n_checks++; if (cache_addr !== 32'h100)      begin n_fail++; $display("FAIL word_addr: got %h want 00000100", cache_addr); end
        n_checks++; if (lanes() !== 32'hDEADBEEF)    begin n_fail++; $display("FAIL word_lanes: got %h want deadbeef", lanes()); end
        n_checks++; if (cache_byte_en !== 4'b1111)   begin n_fail++; $display("FAIL word_be: got %b want 1111", cache_byte_en); end
        tick();
        n_checks++; if (buf_empty !== 1'b1)          begin n_fail++; $display("FAIL word_drained: got %0b want 1", buf_empty); end
        n_checks++; if (cache_req !== 1'b0)          begin n_fail++; $display("FAIL word_req_low: got %0b want 0", cache_req); end
        cache_ack = 1'b0;
    endtask

    // Back-to-back byte stores with ack held high: one in and one out every cycle.
    task automatic test_back_to_back_bytes();
        logic [31:0] exp_lanes [4];
        logic [3:0]  exp_be    [4];
        exp_lanes[0] = 32'h11000000; exp_be[0] = 4'b1000;
        exp_lanes[1] = 32'h00220000; exp_be[1] = 4'b0100;
        exp_lanes[2] = 32'h00003300; exp_be[2] = 4'b0010;
        exp_lanes[3] = 32'h00000044; exp_be[3] = 4'b0001;
        cache_ack  = 1'b1;
        st_is_word = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h100 + 32'(i);
            st_data  = 32'hABCDEF00 | (32'h11 * 32'(i + 1));
            tick();
            n_checks++; if (cache_addr !== 32'h100)      begin n_fail++; $display("FAIL byte%0d_addr: got %h want 00000100", i, cache_addr); end
            n_checks++; if (lanes() !== exp_lanes[i])    begin n_fail++; $display("FAIL byte%0d_lanes: got %h want %h", i, lanes(), exp_lanes[i]); end
            n_checks++; if (cache_byte_en !== exp_be[i]) begin n_fail++; $display("FAIL byte%0d_be: got %b want %b", i, cache_byte_en, exp_be[i]); end
            n_checks++; if (cache_req !== 1'b1)          begin n_fail++; $display("FAIL byte%0d_req: got %0b want 1", i, cache_req); end
        end
        st_valid = 1'b0;
        tick();
        n_checks++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL bytes_drained: got %0b want 1", buf_empty); end
        cache_ack = 1'b0;
    endtask

    task automatic test_full();
        int accepted = 0;
        cache_ack  = 1'b0;
        st_is_word = 1'b1;
        for (int k = 0; k < 5; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'h200 + 32'(4 * k);
            st_data  = 32'h10000000 + 32'(k);
            n_checks++; if (st_ready !== (k < 4)) begin n_fail++; $display("FAIL full_ready_%0d: got %0b want %0b", k, st_ready, (k < 4)); end
            if (st_ready) accepted++;
            tick();
        end
        st_valid = 1'b0;
        n_checks++; if (accepted != 4)            begin n_fail++; $display("FAIL full_accepted: got %0d want 4", accepted); end
        n_checks++; if (cache_addr !== 32'h200)   begin n_fail++; $display("FAIL full_head: got %h want 00000200", cache_addr); end
        cache_ack = 1'b1;
        n_checks++; if (st_ready !== 1'b0)        begin n_fail++; $display("FAIL full_pop_no_ready: got %0b want 0", st_ready); end
        tick();
        cache_ack = 1'b0;
        n_checks++; if (st_ready !== 1'b1)        begin n_fail++; $display("FAIL full_ready_after_pop: got %0b want 1", st_ready); end
        cache_ack = 1'b1;
        for (int k = 1; k < 4; k++) begin
            n_checks++; if (cache_addr !== 32'h200 + 32'(4 * k)) begin n_fail++; $display("FAIL full_order_addr%0d: got %h want %h", k, cache_addr, 32'h200 + 32'(4 * k)); end
            n_checks++; if (lanes() !== 32'h10000000 + 32'(k))   begin n_fail++; $display("FAIL full_order_data%0d: got %h want %h", k, lanes(), 32'h10000000 + 32'(k)); end
            tick();
        end
        cache_ack = 1'b0;
        n_checks++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %0b want 1", buf_empty); end
    endtask

    task automatic test_halt_drain();
        cache_ack  = 1'b0;
        st_is_word = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st_valid          = 1'b1;
            st_addr           = 32'h300 + 32'(4 * k);
            st_data           = 32'h30000000 + 32'(k);
            halted_controller = (k == 2);
            tick();
        end
        st_valid          = 1'b0;
        halted_controller = 1'b0;
        n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready_drop: got %0b want 0", st_ready); end
        n_checks++; if (halted !== 1'b0)   begin n_fail++; $display("FAIL halt_early: got %0b want 0", halted); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            n_checks++; if (cache_req !== 1'b1)                  begin n_fail++; $display("FAIL halt_req%0d: got %0b want 1", k, cache_req); end
            n_checks++; if (cache_addr !== 32'h300 + 32'(4 * k)) begin n_fail++; $display("FAIL halt_addr%0d: got %h want %h", k, cache_addr, 32'h300 + 32'(4 * k)); end
            cache_ack = 1'b1;
            tick();
            cache_ack = 1'b0;
        end
        n_checks++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL halt_drained: got %0b want 1", buf_empty); end
        n_checks++; if (halted !== 1'b0)    begin n_fail++; $display("FAIL halt_too_soon: got %0b want 0", halted); end
        tick();
        n_checks++; if (halted !== 1'b1)    begin n_fail++; $display("FAIL halt_rise: got %0b want 1", halted); end
        st_valid = 1'b1;
        tick();
        tick();
        st_valid = 1'b0;
        n_checks++; if (halted !== 1'b1)    begin n_fail++; $display("FAIL halt_sticky: got %0b want 1", halted); end
        n_checks++; if (st_ready !== 1'b0)  begin n_fail++; $display("FAIL halt_ready_low: got %0b want 0", st_ready); end
        n_checks++; if (cache_req !== 1'b0) begin n_fail++; $display("FAIL halt_no_write: got %0b want 0", cache_req); end
        do_reset();
        n_checks++; if (halted !== 1'b0)    begin n_fail++; $display("FAIL halt_cleared: got %0b want 0", halted); end
    endtask

    task automatic test_halt_empty();
        halted_controller = 1'b1;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL empty_halt_pre: got %0b want 0", halted); end
        tick();
        halted_controller = 1'b0;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL empty_halt_rise: got %0b want 1", halted); end
        do_reset();
    endtask

    task automatic test_misalign();
        cache_ack  = 1'b1;
        st_valid   = 1'b1;
        st_is_word = 1'b1;
        st_addr    = 32'h102;
        st_data    = 32'hCAFEF00D;
        tick();
        st_valid = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %0b want 1", misaligned); end
        n_checks++; if (cache_req !== 1'b0)  begin n_fail++; $display("FAIL mis_no_req: got %0b want 0", cache_req); end
        tick();
        n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %0b want 0", misaligned); end
        n_checks++; if (cache_req !== 1'b0)  begin n_fail++; $display("FAIL mis_no_req_late: got %0b want 0", cache_req); end
`else
        n_checks++; if (misaligned !== 1'b0)        begin n_fail++; $display("FAIL mis_tied: got %0b want 0", misaligned); end
        n_checks++; if (cache_req !== 1'b1)         begin n_fail++; $display("FAIL mis_req: got %0b want 1", cache_req); end
        n_checks++; if (cache_addr !== 32'h100)     begin n_fail++; $display("FAIL mis_addr: got %h want 00000100", cache_addr); end
        n_checks++; if (cache_byte_en !== 4'b1111)  begin n_fail++; $display("FAIL mis_be: got %b want 1111", cache_byte_en); end
        n_checks++; if (lanes() !== 32'hCAFEF00D)   begin n_fail++; $display("FAIL mis_lanes: got %h want cafef00d", lanes()); end
        tick();
`endif
        cache_ack = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_write();
        cache_ack  = 1'b0;
        st_is_word = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'h400 + 32'(4 * k);
            st_data  = 32'h40000000 + 32'(k);
            tick();
        end
        st_valid = 1'b0;
        n_checks++; if (cache_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %0b want 1", cache_req); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (cache_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %0b want 0", cache_req); end
        n_checks++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got %0b want 1", buf_empty); end
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (cache_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after%0d: got %0b want 0", k, cache_req); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        st_valid          = 1'b0;
        st_addr           = '0;
        st_data           = '0;
        st_is_word        = 1'b0;
        cache_ack         = 1'b0;
        halted_controller = 1'b0;
        test_reset();
        test_word_store();
        test_back_to_back_bytes();
        test_full();
        test_halt_drain();
        test_halt_empty();
        test_misalign();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
